// File: rtl/reg_writeback_queue_pkg.sv
// Shared widths, the zero-register address and the queue entry layout for the
// register write-back queue.
package wb_pkg;
    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] XZR_ADDR = 5'd31;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/reg_writeback_queue_if.sv
// Producer, bank-drain and bypass signals of the write-back queue.
// The slave modport is the queue side; master is the surrounding pipeline.
interface reg_writeback_queue_if #(
    parameter int DEPTH = 4
);
    import wb_pkg::*;
    localparam int CW = $clog2(DEPTH) + 1;

    logic              iExValid;
    logic              oExReady;
    logic [ADDR_W-1:0] iExRd;
    logic [DATA_W-1:0] iExData;
    logic              iMemValid;
    logic              oMemReady;
    logic [ADDR_W-1:0] iMemRd;
    logic [DATA_W-1:0] iMemData;
    logic              iDrainEn;
    logic              oRegWrite;
    logic [ADDR_W-1:0] oWriteAddr;
    logic [DATA_W-1:0] oWriteData;
    logic [ADDR_W-1:0] iLookupRm;
    logic [ADDR_W-1:0] iLookupRn;
    logic              oHitRm;
    logic [DATA_W-1:0] oDataRm;
    logic              oHitRn;
    logic [DATA_W-1:0] oDataRn;
    logic [CW-1:0]     oCount;
    logic              oEmpty;
    logic              oFull;

    modport slave (
        input  iExValid, iExRd, iExData, iMemValid, iMemRd, iMemData,
        input  iDrainEn, iLookupRm, iLookupRn,
        output oExReady, oMemReady, oRegWrite, oWriteAddr, oWriteData,
        output oHitRm, oDataRm, oHitRn, oDataRn, oCount, oEmpty, oFull
    );

    modport master (
        output iExValid, iExRd, iExData, iMemValid, iMemRd, iMemData,
        output iDrainEn, iLookupRm, iLookupRn,
        input  oExReady, oMemReady, oRegWrite, oWriteAddr, oWriteData,
        input  oHitRm, oDataRm, oHitRn, oDataRn, oCount, oEmpty, oFull
    );
endinterface

// File: rtl/reg_writeback_queue_fifo.sv
// In-order entry storage for the write-back queue. The view ports present the
// occupied entries in age order (index 0 = head) for the bypass search.
module wb_fifo
    import wb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  wb_entry_t        push_entry,
    input  logic             pop,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output wb_entry_t        view_entry [DEPTH],
    output logic [DEPTH-1:0] view_valid
);
    wb_entry_t      mem_q [DEPTH];
    wb_entry_t      mem_d [DEPTH];
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]  count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            view_entry[i] = mem_q[rd_ptr_q + PW'(i)];
            view_valid[i] = (CW'(i) < count_q);
        end
    end

    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
endmodule

// File: rtl/reg_writeback_queue.sv
// Write-back queue in front of the register bank: arbitrates EX/MEM results,
// drops zero-register writes, drains in order and serves pending-value bypass.
module reg_writeback_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic                  iCLK,
    input logic                  iReset_n,
    reg_writeback_queue_if.slave wb
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             fifo_push;
    logic             fifo_pop;
    logic [CW-1:0]    fifo_count;
    logic             fifo_empty;
    logic             fifo_full;
    wb_entry_t        view_entry [DEPTH];
    logic [DEPTH-1:0] view_valid;
    wb_entry_t        sel_entry;
    logic             space, mem_fire, ex_fire;
    logic             hit_rm, hit_rn;
    logic [DATA_W-1:0] data_rm, data_rn;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (iCLK),
        .rst_n      (iReset_n),
        .push       (fifo_push),
        .push_entry (sel_entry),
        .pop        (fifo_pop),
        .count      (fifo_count),
        .empty      (fifo_empty),
        .full       (fifo_full),
        .view_entry (view_entry),
        .view_valid (view_valid)
    );

    // A pop in the same cycle frees the slot a push needs, so full + drain still accepts.
    assign fifo_pop = wb.iDrainEn & ~fifo_empty;
    assign space    = ~fifo_full | fifo_pop;
    assign mem_fire = wb.iMemValid & space;
    assign ex_fire  = wb.iExValid & space & ~wb.iMemValid;

    always_comb begin
        sel_entry = mem_fire ? wb_entry_t'{rd: wb.iMemRd, data: wb.iMemData}
                             : wb_entry_t'{rd: wb.iExRd,  data: wb.iExData};
        fifo_push = (mem_fire | ex_fire) & (sel_entry.rd != XZR_ADDR);
    end

    // Ascending scan runs oldest to newest, so the last match is the newest value.
    always_comb begin
        hit_rm  = 1'b0;
        data_rm = '0;
        hit_rn  = 1'b0;
        data_rn = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (view_valid[i] && view_entry[i].rd == wb.iLookupRm && wb.iLookupRm != XZR_ADDR) begin
                hit_rm  = 1'b1;
                data_rm = view_entry[i].data;
            end
            if (view_valid[i] && view_entry[i].rd == wb.iLookupRn && wb.iLookupRn != XZR_ADDR) begin
                hit_rn  = 1'b1;
                data_rn = view_entry[i].data;
            end
        end
    end

    assign wb.oMemReady  = space;
    assign wb.oExReady   = space & ~wb.iMemValid;
    assign wb.oRegWrite  = fifo_pop;
    assign wb.oWriteAddr = fifo_empty ? '0 : view_entry[0].rd;
    assign wb.oWriteData = fifo_empty ? '0 : view_entry[0].data;
    assign wb.oHitRm     = hit_rm;
    assign wb.oDataRm    = data_rm;
    assign wb.oHitRn     = hit_rn;
    assign wb.oDataRn    = data_rn;
    assign wb.oCount     = fifo_count;
    assign wb.oEmpty     = fifo_empty;
    assign wb.oFull      = fifo_full;
endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for reg_writeback_queue: reset, drain latency, arbitration,
// full/stall, bypass and zero-register handling.
module tb_reg_writeback_queue;
    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    reg_writeback_queue_if #(.DEPTH(4)) bus ();

    reg_writeback_queue #(.DEPTH(4)) dut (
        .iCLK     (clk),
        .iReset_n (rst_n),
        .wb       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        bus.iExValid  = 1'b0;
        bus.iExRd     = '0;
        bus.iExData   = '0;
        bus.iMemValid = 1'b0;
        bus.iMemRd    = '0;
        bus.iMemData  = '0;
    endtask

    task automatic set_ex(input logic v, input logic [4:0] rd, input logic [63:0] d);
        bus.iExValid = v;
        bus.iExRd    = rd;
        bus.iExData  = d;
    endtask

    task automatic set_mem(input logic v, input logic [4:0] rd, input logic [63:0] d);
        bus.iMemValid = v;
        bus.iMemRd    = rd;
        bus.iMemData  = d;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        idle_inputs();
        bus.iDrainEn  = 1'b0;
        bus.iLookupRm = '0;
        bus.iLookupRn = '0;
        #2;
        check("rst_count", bus.oCount, 0);
        check("rst_empty", bus.oEmpty, 1);
        check("rst_full", bus.oFull, 0);
        check("rst_regwrite", bus.oRegWrite, 0);
        check("rst_waddr", bus.oWriteAddr, 0);
        check("rst_wdata", bus.oWriteData, 0);
        check("rst_hitrm", bus.oHitRm, 0);
        check("rst_hitrn", bus.oHitRn, 0);
        tick();
        tick();
        rst_n = 1'b1;
        settle();
        check("rst_exready", bus.oExReady, 1);
        check("rst_memready", bus.oMemReady, 1);

        // single EX write, drain enabled
        bus.iDrainEn = 1'b1;
        set_ex(1, 5'd5, 64'h1234);
        settle();
        check("ex1_ready", bus.oExReady, 1);
        check("ex1_no_early_write", bus.oRegWrite, 0);
        tick();
        idle_inputs();
        bus.iLookupRm = 5'd5;
        settle();
        check("ex1_regwrite", bus.oRegWrite, 1);
        check("ex1_waddr", bus.oWriteAddr, 5);
        check("ex1_wdata", bus.oWriteData, 64'h1234);
        check("ex1_bypass_hit", bus.oHitRm, 1);
        check("ex1_bypass_data", bus.oDataRm, 64'h1234);
        tick();
        settle();
        check("ex1_empty_after", bus.oEmpty, 1);
        check("ex1_regwrite_after", bus.oRegWrite, 0);
        check("ex1_bypass_gone", bus.oHitRm, 0);

        // EX/MEM contention: MEM wins, EX stalls one cycle
        bus.iDrainEn = 1'b0;
        set_ex(1, 5'd1, 64'hA);
        set_mem(1, 5'd2, 64'hB);
        settle();
        check("cont_memready", bus.oMemReady, 1);
        check("cont_exready", bus.oExReady, 0);
        tick();
        set_mem(0, 5'd0, 64'h0);
        settle();
        check("cont_count1", bus.oCount, 1);
        check("cont_exready2", bus.oExReady, 1);
        tick();
        idle_inputs();
        bus.iDrainEn = 1'b1;
        settle();
        check("cont_count2", bus.oCount, 2);
        check("cont_d0_addr", bus.oWriteAddr, 2);
        check("cont_d0_data", bus.oWriteData, 64'hB);
        tick();
        check("cont_d1_addr", bus.oWriteAddr, 1);
        check("cont_d1_data", bus.oWriteData, 64'hA);
        tick();
        check("cont_empty", bus.oEmpty, 1);

        // fill with drain held, then push together with a pop
        bus.iDrainEn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_ex(1, 5'(10 + i), 64'h100 + 64'(i));
            settle();
            check("fill_exready", bus.oExReady, 1);
            tick();
        end
        idle_inputs();
        settle();
        check("fill_full", bus.oFull, 1);
        check("fill_count", bus.oCount, 4);
        check("fill_exready0", bus.oExReady, 0);
        check("fill_memready0", bus.oMemReady, 0);
        bus.iDrainEn = 1'b1;
        set_mem(1, 5'd14, 64'h200);
        settle();
        check("fill_memready_pop", bus.oMemReady, 1);
        check("fill_regwrite", bus.oRegWrite, 1);
        check("fill_head", bus.oWriteAddr, 10);
        tick();
        idle_inputs();
        settle();
        check("fill_count_kept", bus.oCount, 4);
        check("fill_full_kept", bus.oFull, 1);
        for (int i = 0; i < 4; i++) begin
            check("fill_drain_addr", bus.oWriteAddr, 64'(11 + i));
            check("fill_drain_data", bus.oWriteData, (i == 3) ? 64'h200 : 64'h101 + 64'(i));
            tick();
        end
        check("fill_empty_end", bus.oEmpty, 1);

        // bypass: newest pending write wins, enqueue-in-progress does not hit
        bus.iDrainEn  = 1'b0;
        bus.iLookupRm = 5'd7;
        bus.iLookupRn = 5'd31;
        set_ex(1, 5'd7, 64'h11);
        settle();
        check("byp_no_hit_enq", bus.oHitRm, 0);
        tick();
        set_ex(1, 5'd7, 64'h22);
        settle();
        check("byp_hit_old", bus.oHitRm, 1);
        check("byp_data_old", bus.oDataRm, 64'h11);
        tick();
        idle_inputs();
        settle();
        check("byp_hit_new", bus.oHitRm, 1);
        check("byp_data_new", bus.oDataRm, 64'h22);
        check("byp_xzr_nohit", bus.oHitRn, 0);
        check("byp_xzr_data", bus.oDataRn, 0);
        bus.iLookupRn = 5'd8;
        settle();
        check("byp_miss", bus.oHitRn, 0);
        bus.iDrainEn = 1'b1;
        settle();
        check("byp_pop0_hit", bus.oHitRm, 1);
        check("byp_pop0_data", bus.oDataRm, 64'h22);
        tick();
        check("byp_pop1_hit", bus.oHitRm, 1);
        check("byp_pop1_data", bus.oDataRm, 64'h22);
        check("byp_pop1_wdata", bus.oWriteData, 64'h22);
        tick();
        check("byp_final_nohit", bus.oHitRm, 0);

        // zero-register write is accepted and dropped
        set_ex(1, 5'd31, 64'hFF);
        settle();
        check("xzr_exready", bus.oExReady, 1);
        tick();
        idle_inputs();
        settle();
        check("xzr_count", bus.oCount, 0);
        check("xzr_regwrite", bus.oRegWrite, 0);
        tick();
        check("xzr_regwrite2", bus.oRegWrite, 0);

        // reset with three entries pending: nothing must reach the bank
        bus.iDrainEn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_ex(1, 5'(20 + i), 64'h300 + 64'(i));
            tick();
        end
        idle_inputs();
        settle();
        check("mrst_count3", bus.oCount, 3);
        bus.iDrainEn = 1'b1;
        rst_n = 1'b0;
        settle();
        check("mrst_count", bus.oCount, 0);
        check("mrst_empty", bus.oEmpty, 1);
        check("mrst_regwrite", bus.oRegWrite, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("mrst_no_write", bus.oRegWrite, 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
